fifo_spram_reader: RTL and testbench

FIFO_SPRAM_READER -- requirements
Module: fifo_spram_reader

---
 rtl/fifo_spram_reader.sv | 43 ++++
 tb/tb_fifo_spram_reader.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fifo_spram_reader.sv
// fifo_spram_reader: pulls bytes from a one-cycle-latency SPRAM FIFO into a 2-entry skid buffer.
// Reads stall on FIFO write cycles, since the shared SPRAM address then points at the write pointer.
module fifo_spram_reader #(
  parameter int WIDTH = 8,
  parameter int SKID  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_data_available,
  input  logic             fifo_write_strobe,
  input  logic [WIDTH-1:0] fifo_read_data,
  output logic             fifo_read_strobe,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  logic [1:0]       r_occ;
  logic             r_inflight;
  logic [WIDTH-1:0] r_d0, r_d1;
  logic             w_pop;
  logic [2:0]       w_level;
  logic [1:0]       w_wi;
  assign out_valid = r_occ != 2'd0;
  assign out_data  = r_d0;
  assign w_pop     = out_valid && out_ready;
  assign w_level   = {1'b0, r_occ} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_wi      = r_occ - {1'b0, w_pop};
  // counting the inflight fetch keeps a capture from ever landing in a full buffer
  assign fifo_read_strobe = fifo_data_available && !fifo_write_strobe && !reset && (w_level < 3'(SKID));
  always_ff @(posedge clk) begin
    if (reset) begin
      r_occ      <= '0;
      r_inflight <= 1'b0;
      r_d0       <= '0;
      r_d1       <= '0;
    end else begin
      r_inflight <= fifo_read_strobe;
      r_occ      <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
      r_d0       <= (r_inflight && w_wi == 2'd0) ? fifo_read_data : w_pop ? r_d1 : r_d0;
      r_d1       <= (r_inflight && w_wi == 2'd1) ? fifo_read_data : r_d1;
    end
  end
endmodule

// File: tb/tb_fifo_spram_reader.sv
// tb_fifo_spram_reader: SPRAM FIFO environment model plus scenario tasks and a random scoreboard run.
module tb_fifo_spram_reader;
  logic clk = 0, reset = 1, fifo_write_strobe = 0, out_ready = 0;
  logic fifo_data_available, fifo_read_strobe, out_valid;
  logic [7:0] fifo_read_data, out_data, wd;
  logic [7:0] mem [0:1023];
  logic [9:0] wp, rp;
  int total = 0, bad = 0;
  logic obs_s, obs_v, obs_pop, obs_av;
  logic [7:0] obs_d;

  fifo_spram_reader #(.WIDTH(8), .SKID(2)) dut (
    .clk(clk), .reset(reset), .fifo_data_available(fifo_data_available),
    .fifo_write_strobe(fifo_write_strobe), .fifo_read_data(fifo_read_data),
    .fifo_read_strobe(fifo_read_strobe), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data));

  always #5 clk = ~clk;

  assign fifo_data_available = rp != wp;
  always @(posedge clk) begin
    if (reset) begin
      wp <= 0; rp <= 0; fifo_read_data <= 0;
    end else begin
      if (fifo_write_strobe) begin mem[wp] <= wd; wp <= wp + 1; end
      if (fifo_read_strobe) begin fifo_read_data <= mem[rp]; rp <= rp + 1; end
    end
  end

  task automatic tick(input logic rs, input logic wr, input logic [7:0] d, input logic rdy);
    @(negedge clk);
    reset = rs; fifo_write_strobe = wr; wd = d; out_ready = rdy;
    #1;
    obs_s = fifo_read_strobe; obs_v = out_valid; obs_d = out_data;
    obs_pop = out_valid && out_ready; obs_av = fifo_data_available;
  endtask

  task automatic test_reset;
    tick(1, 0, 0, 0); tick(1, 0, 0, 0);
    total++; if (obs_v !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", obs_v); end
    total++; if (obs_d !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", obs_d); end
    total++; if (obs_s !== 1'b0) begin bad++; $display("FAIL reset_strobe got=%b want=0", obs_s); end
  endtask

  task automatic test_burst;
    logic [7:0] e [3];
    e[0] = 8'h11; e[1] = 8'h22; e[2] = 8'h33;
    tick(0, 1, 8'h11, 1); tick(0, 1, 8'h22, 1);
    total++; if (obs_s !== 1'b0) begin bad++; $display("FAIL burst_write_stall got=%b want=0", obs_s); end
    tick(0, 1, 8'h33, 1);
    for (int c = 0; c < 6; c++) begin
      tick(0, 0, 0, 1);
      total++; if (obs_s !== (c < 3)) begin bad++; $display("FAIL burst_strobe c=%0d got=%b want=%b", c, obs_s, c < 3); end
      if (c >= 2 && c <= 4) begin
        total++; if (obs_v !== 1'b1 || obs_d !== e[c-2]) begin bad++; $display("FAIL burst_data c=%0d got=%b/%h want=1/%h", c, obs_v, obs_d, e[c-2]); end
      end else begin
        total++; if (obs_v !== 1'b0) begin bad++; $display("FAIL burst_idle c=%0d got=%b want=0", c, obs_v); end
      end
    end
  endtask

  task automatic test_backpressure;
    int n = 0, k = 0, gaps = 0;
    for (int i = 0; i < 5; i++) begin tick(0, 1, 8'(8'hA0 + i), 0); n += int'(obs_s); end
    for (int i = 0; i < 6; i++) begin tick(0, 0, 0, 0); n += int'(obs_s); end
    total++; if (n != 2) begin bad++; $display("FAIL bp_strobes got=%0d want=2", n); end
    total++; if (obs_v !== 1'b1 || obs_d !== 8'hA0) begin bad++; $display("FAIL bp_hold got=%b/%h want=1/a0", obs_v, obs_d); end
    for (int i = 0; i < 20 && k < 5; i++) begin
      tick(0, 0, 0, 1);
      n += int'(obs_s);
      if (obs_pop) begin
        total++; if (obs_d !== 8'(8'hA0 + k)) begin bad++; $display("FAIL bp_order k=%0d got=%h want=%h", k, obs_d, 8'(8'hA0 + k)); end
        k++;
      end else if (k > 0) gaps++;
    end
    total++; if (k != 5) begin bad++; $display("FAIL bp_count got=%0d want=5", k); end
    total++; if (n != 5) begin bad++; $display("FAIL bp_total_strobes got=%0d want=5", n); end
    total++; if (gaps != 0) begin bad++; $display("FAIL bp_gaps got=%0d want=0", gaps); end
  endtask

  task automatic test_collision;
    int written = 0, k = 0, clash = 0;
    logic wr;
    for (int c = 0; c < 200 && k < 16; c++) begin
      wr = (c % 3 == 0) && written < 16;
      tick(0, wr, 8'(8'h50 + written), 1);
      if (wr) written++;
      if (obs_s && wr) clash++;
      if (obs_pop) begin
        total++; if (obs_d !== 8'(8'h50 + k)) begin bad++; $display("FAIL coll_order k=%0d got=%h want=%h", k, obs_d, 8'(8'h50 + k)); end
        k++;
      end
    end
    total++; if (k != 16) begin bad++; $display("FAIL coll_count got=%0d want=16", k); end
    total++; if (clash != 0) begin bad++; $display("FAIL coll_strobe_on_write got=%0d want=0", clash); end
    tick(0, 0, 0, 1);
    total++; if (obs_v !== 1'b0) begin bad++; $display("FAIL coll_extra got=%b want=0", obs_v); end
  endtask

  task automatic test_reset_midfetch;
    logic found = 0;
    tick(0, 1, 8'hC1, 0); tick(0, 1, 8'hC2, 0);
    tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    total++; if (obs_s !== 1'b1) begin bad++; $display("FAIL mid_second_fetch got=%b want=1", obs_s); end
    tick(1, 0, 0, 0);
    total++; if (obs_v !== 1'b1 || obs_d !== 8'hC1) begin bad++; $display("FAIL mid_pre got=%b/%h want=1/c1", obs_v, obs_d); end
    total++; if (obs_s !== 1'b0) begin bad++; $display("FAIL mid_reset_strobe got=%b want=0", obs_s); end
    tick(0, 0, 0, 1);
    total++; if (obs_v !== 1'b0 || obs_s !== 1'b0) begin bad++; $display("FAIL mid_post got=%b/%b want=0/0", obs_v, obs_s); end
    tick(0, 1, 8'h7E, 1);
    for (int i = 0; i < 10 && !found; i++) begin
      tick(0, 0, 0, 1);
      if (obs_pop) begin
        found = 1;
        total++; if (obs_d !== 8'h7E) begin bad++; $display("FAIL mid_first got=%h want=7e", obs_d); end
      end
    end
    total++; if (!found) begin bad++; $display("FAIL mid_timeout got=0 want=1"); end
  endtask

  task automatic test_random;
    logic [7:0] sb [$];
    int written = 0, popped = 0, outst = 0, over = 0, clash = 0, empty_rd = 0;
    logic wr;
    logic [7:0] d;
    for (int c = 0; c < 60000 && popped < 10000; c++) begin
      wr = written < 10000 && 10'(wp - rp) < 10'd1000 && $urandom_range(1, 0) == 1;
      d = 8'($urandom);
      tick(0, wr, d, $urandom_range(1, 0) == 1);
      if (wr) begin sb.push_back(d); written++; end
      if (obs_s && wr) clash++;
      if (obs_s && !obs_av) empty_rd++;
      if (outst > 2) over++;
      outst += int'(obs_s) - int'(obs_pop);
      if (obs_pop) begin
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL rand_spurious n=%0d got=%h want=none", popped, obs_d); end
        else begin
          if (obs_d !== sb[0]) begin bad++; $display("FAIL rand_order n=%0d got=%h want=%h", popped, obs_d, sb[0]); end
          void'(sb.pop_front());
        end
        popped++;
      end
    end
    total++; if (popped != 10000) begin bad++; $display("FAIL rand_count got=%0d want=10000", popped); end
    total++; if (over != 0) begin bad++; $display("FAIL rand_occ_over got=%0d want=0", over); end
    total++; if (clash != 0) begin bad++; $display("FAIL rand_strobe_on_write got=%0d want=0", clash); end
    total++; if (empty_rd != 0) begin bad++; $display("FAIL rand_strobe_empty got=%0d want=0", empty_rd); end
  endtask

  initial begin
    test_reset;
    test_burst;
    test_backpressure;
    test_collision;
    test_reset_midfetch;
    test_reset;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
